layer_mem_ctrl: RTL and testbench
=================================

# layer_mem_ctrl

Parametrised, sequenced memory controller for one shared on-chip buffer (WH, num_node or feature storage) used by NUM_LAYERS GAT layers. It owns the layer schedule instead of taking a layer select as input: a PS load phase is followed by each layer in turn, with a drain gap between layers, then a PS readback phase. It arbitrates PS and per-layer access, delivers reads with a configurable latency and a valid strobe, and counts dropped accesses. It sits between the PS/AXI loader and the conv pipelines, above a single BRAM instance.

## Interface
- DATA_WIDTH, 32, word width
- DEPTH, 43328, words; ADDR_W = $clog2(DEPTH)
- NUM_LAYERS, 2, layer clients (1..8); LAYER_W = max(1,$clog2(NUM_LAYERS))
- READ_LATENCY, 1, cycles from rd_en to rd_valid (1..3)
- ERR_W, 16, width of the dropped-access counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ps_wr_en / ps_wr_addr / ps_wr_data  in  1 / ADDR_W / DATA_WIDTH  PS write
- ps_rd_en / ps_rd_addr  in  1 / ADDR_W  PS readback
- ps_load_done  in  1  pulse: initial load complete
- ps_restart  in  1  pulse: begin new inference
- layer_wr_en  in  NUM_LAYERS  per-layer write enable
- layer_wr_addr  in  NUM_LAYERS*ADDR_W  packed, layer k at [k*ADDR_W +: ADDR_W]
- layer_wr_data  in  NUM_LAYERS*DATA_WIDTH  packed
- layer_rd_en  in  NUM_LAYERS
- layer_rd_addr  in  NUM_LAYERS*ADDR_W  packed
- layer_done  in  NUM_LAYERS  pulse from layer k when finished
- gat_layer  out  LAYER_W  active layer index
- layer_start  out  NUM_LAYERS  one-cycle start pulse to layer k
- rd_data  out  DATA_WIDTH  read data, broadcast
- rd_valid  out  1  rd_data valid
- all_done  out  1  schedule complete
- drop_cnt  out  ERR_W  saturating count of rejected accesses

## Operation
- States: LOAD, RUN, DRAIN, DONE. Reset → LOAD, gat_layer=0.
- LOAD: only PS writes accepted; all reads and layer writes dropped. ps_load_done → RUN, layer 0.
- RUN(k): only layer k's writes/reads reach the BRAM; PS accesses and other layers' accesses dropped. layer_done[k] → DRAIN. layer_done[j≠k] is ignored and does not count as a drop.
- DRAIN: READ_LATENCY cycles with no new access accepted; in-flight reads still complete. Then, if k<NUM_LAYERS-1, go to RUN(k+1); otherwise go to DONE.
- DONE: all_done=1. PS reads and writes are accepted. ps_restart → LOAD, gat_layer=0. ps_restart is ignored in all other states.
- Same-cycle write and read to the same address: the read returns the old data (read-first).
- Dropped access: any asserted rd_en/wr_en that is not accepted adds 1 per cycle, even if several are dropped in that cycle. drop_cnt saturates at 2^ERR_W−1 and clears only on reset.

## Timing
- Reset values: gat_layer=0, layer_start=0, rd_data=0, rd_valid=0, all_done=0, drop_cnt=0. Asserting rst_n low mid-read discards the pipeline, so no rd_valid is produced.
- Read: accepted rd_en at cycle t → rd_valid=1 with data at t+READ_LATENCY. There is no backpressure.
- Write: committed at the accepting edge.
- ps_load_done at t → gat_layer=0 and layer_start[0]=1 at t+1.
- layer_done[k] at t → DRAIN during t+1..t+READ_LATENCY → layer_start[k+1]=1 and gat_layer=k+1 at t+READ_LATENCY+1.
- Final layer: all_done=1 at t+READ_LATENCY+1.
- layer_start is high for exactly one cycle per layer entry.

## Structure
- The shared package gat_pkg holds the state enum typedef mem_ctrl_state_e (LOAD/RUN/DRAIN/DONE) and a MAX_LAYERS=8 constant.
- The storage is the existing BRAM module, with wea tied to the arbitrated write enable.
- One sub-module, read_valid_pipe. It delays rd_en by READ_LATENCY and adds READ_LATENCY−1 data register stages after the BRAM output.

## Test plan
- PS writes addr 5=0xA5 in LOAD, then pulses ps_load_done → at the next cycle layer_start=2'b01 and gat_layer=0. Layer 0 reads addr 5 → rd_valid with 0xA5 after READ_LATENCY cycles.
- In RUN(0), layer 1 writes addr 7=0x11 → the write is dropped, drop_cnt=1, and a layer 0 read of addr 7 returns the prior value.
- READ_LATENCY=3, layer 0 reads then pulses layer_done on the same cycle → the read completes, and layer_start[1] fires 4 cycles after layer_done.
- Layer 1 writes and reads addr 9 in the same cycle (old 0x0, new 0x22) → the read returns 0x0, and the next read returns 0x22.
- Last layer_done → all_done=1 after the drain. PS reads addr 9 → 0x22. ps_restart → LOAD with all_done=0.
- ERR_W=2, five dropped accesses → drop_cnt=3. Assert rst_n low mid-read → all outputs 0 and no rd_valid.

Source files
------------

// File: rtl/gat_pkg.sv
// Shared GAT definitions: memory-controller schedule states and layer-count limit.
package gat_pkg;
  typedef enum logic [1:0] {LOAD, RUN, DRAIN, DONE} mem_ctrl_state_e;
  localparam int MAX_LAYERS = 8;
endpackage

// File: rtl/bram.sv
// Simple dual-port block RAM, one write port and one registered read port.
// Reads return the pre-write contents on an address collision (read-first).
module bram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 43328,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_wea,
  input  logic [ADDR_W-1:0]     i_addra,
  input  logic [DATA_WIDTH-1:0] i_dina,
  input  logic                  i_enb,
  input  logic [ADDR_W-1:0]     i_addrb,
  output logic [DATA_WIDTH-1:0] o_doutb
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_doutb;

  always_ff @(posedge i_clk) begin
    if (i_wea) r_mem[i_addra] <= i_dina;
    if (i_enb) r_doutb <= r_mem[i_addrb];
  end

  assign o_doutb = r_doutb;
endmodule

// File: rtl/read_valid_pipe.sv
// Delays the accepted read strobe by READ_LATENCY and adds READ_LATENCY-1 data stages
// behind the BRAM output register. Data is forced to zero whenever it is not valid.
module read_valid_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd_en,
  input  logic [DATA_WIDTH-1:0] i_bram_dout,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid
);
  logic [READ_LATENCY-1:0] r_vld;
  logic [DATA_WIDTH-1:0]   w_dat [READ_LATENCY];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_rd_en;
      for (int i = 1; i < READ_LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  assign w_dat[0] = i_bram_dout;

  for (genvar g = 1; g < READ_LATENCY; g++) begin : g_stage
    logic [DATA_WIDTH-1:0] r_dat;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_dat <= '0;
      else          r_dat <= w_dat[g-1];
    end
    assign w_dat[g] = r_dat;
  end

  assign o_rd_valid = r_vld[READ_LATENCY-1];
  assign o_rd_data  = r_vld[READ_LATENCY-1] ? w_dat[READ_LATENCY-1] : '0;
endmodule

// File: rtl/layer_mem_ctrl.sv
// Sequenced controller for one shared buffer: PS load, each GAT layer in turn with a
// drain gap, then PS readback. Arbitrates access and counts rejected accesses.
module layer_mem_ctrl
  import gat_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 43328,
  parameter int NUM_LAYERS   = 2,
  parameter int READ_LATENCY = 1,
  parameter int ERR_W        = 16,
  localparam int ADDR_W      = $clog2(DEPTH),
  localparam int LAYER_W     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ps_wr_en,
  input  logic [ADDR_W-1:0]                ps_wr_addr,
  input  logic [DATA_WIDTH-1:0]            ps_wr_data,
  input  logic                             ps_rd_en,
  input  logic [ADDR_W-1:0]                ps_rd_addr,
  input  logic                             ps_load_done,
  input  logic                             ps_restart,
  input  logic [NUM_LAYERS-1:0]            layer_wr_en,
  input  logic [NUM_LAYERS*ADDR_W-1:0]     layer_wr_addr,
  input  logic [NUM_LAYERS*DATA_WIDTH-1:0] layer_wr_data,
  input  logic [NUM_LAYERS-1:0]            layer_rd_en,
  input  logic [NUM_LAYERS*ADDR_W-1:0]     layer_rd_addr,
  input  logic [NUM_LAYERS-1:0]            layer_done,
  output logic [LAYER_W-1:0]               gat_layer,
  output logic [NUM_LAYERS-1:0]            layer_start,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid,
  output logic                             all_done,
  output logic [ERR_W-1:0]                 drop_cnt
);
  mem_ctrl_state_e         r_state;
  logic [LAYER_W-1:0]      r_layer;
  logic [NUM_LAYERS-1:0]   r_start;
  logic                    r_all_done;
  logic [1:0]              r_drain_cnt;
  logic [ERR_W-1:0]        r_drop_cnt;

  logic                    w_ps_wr_ok, w_ps_rd_ok, w_drop;
  logic [NUM_LAYERS-1:0]   w_sel;
  logic                    w_we, w_re;
  logic [ADDR_W-1:0]       w_waddr, w_raddr;
  logic [DATA_WIDTH-1:0]   w_wdata, w_bram_dout;

  assign w_ps_wr_ok = ps_wr_en && (r_state == LOAD || r_state == DONE);
  assign w_ps_rd_ok = ps_rd_en && (r_state == DONE);
  assign w_sel      = (r_state == RUN) ? (NUM_LAYERS'(1) << r_layer) : '0;

  // One drop per cycle no matter how many requesters were turned away.
  assign w_drop = (ps_wr_en && !w_ps_wr_ok) || (ps_rd_en && !w_ps_rd_ok) ||
                  (|(layer_wr_en & ~w_sel)) || (|(layer_rd_en & ~w_sel));

  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    w_re    = 1'b0;
    w_raddr = '0;
    if (w_ps_wr_ok) begin
      w_we    = 1'b1;
      w_waddr = ps_wr_addr;
      w_wdata = ps_wr_data;
    end
    if (w_ps_rd_ok) begin
      w_re    = 1'b1;
      w_raddr = ps_rd_addr;
    end
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (w_sel[k] && layer_wr_en[k]) begin
        w_we    = 1'b1;
        w_waddr = layer_wr_addr[k*ADDR_W +: ADDR_W];
        w_wdata = layer_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_sel[k] && layer_rd_en[k]) begin
        w_re    = 1'b1;
        w_raddr = layer_rd_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD;
      r_layer     <= '0;
      r_start     <= '0;
      r_all_done  <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_start <= '0;
      case (r_state)
        LOAD: if (ps_load_done) begin
          r_state <= RUN;
          r_layer <= '0;
          r_start <= NUM_LAYERS'(1);
        end
        RUN: if (layer_done[r_layer]) begin
          r_state     <= DRAIN;
          r_drain_cnt <= '0;
        end
        // Hold off new accesses until reads issued by the outgoing layer have landed.
        DRAIN: if (r_drain_cnt == 2'(READ_LATENCY - 1)) begin
          if (int'(r_layer) < NUM_LAYERS - 1) begin
            r_state <= RUN;
            r_layer <= r_layer + LAYER_W'(1);
            r_start <= NUM_LAYERS'(1) << (r_layer + LAYER_W'(1));
          end else begin
            r_state    <= DONE;
            r_all_done <= 1'b1;
          end
        end else begin
          r_drain_cnt <= r_drain_cnt + 2'd1;
        end
        DONE: if (ps_restart) begin
          r_state    <= LOAD;
          r_layer    <= '0;
          r_all_done <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_drop_cnt <= '0;
    else if (w_drop && !(&r_drop_cnt))   r_drop_cnt <= r_drop_cnt + ERR_W'(1);
  end

  bram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bram (
    .i_clk   (clk),
    .i_wea   (w_we),
    .i_addra (w_waddr),
    .i_dina  (w_wdata),
    .i_enb   (w_re),
    .i_addrb (w_raddr),
    .o_doutb (w_bram_dout)
  );

  read_valid_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_rd_pipe (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rd_en     (w_re),
    .i_bram_dout (w_bram_dout),
    .o_rd_data   (rd_data),
    .o_rd_valid  (rd_valid)
  );

  assign gat_layer   = r_layer;
  assign layer_start = r_start;
  assign all_done    = r_all_done;
  assign drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_layer_mem_ctrl.sv
// Drives two controllers (latency 1 / 16-bit counter, latency 3 / 2-bit counter) from
// shared inputs and checks them against a schedule/memory reference model plus a vector table.
module tb_layer_mem_ctrl;
  localparam int DW = 32;
  localparam int DEPTH = 64;
  localparam int AW = 6;
  localparam int NL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          ps_wr_en, ps_rd_en, ps_load_done, ps_restart;
  logic [AW-1:0] ps_wr_addr, ps_rd_addr;
  logic [DW-1:0] ps_wr_data;
  logic [NL-1:0] layer_wr_en, layer_rd_en, layer_done;
  logic [NL*AW-1:0] layer_wr_addr, layer_rd_addr;
  logic [NL*DW-1:0] layer_wr_data;

  logic          a_layer, b_layer, a_vld, b_vld, a_done, b_done;
  logic [1:0]    a_start, b_start;
  logic [DW-1:0] a_data, b_data;
  logic [15:0]   a_drop;
  logic [1:0]    b_drop;

  layer_mem_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_LAYERS(NL), .READ_LATENCY(1), .ERR_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .ps_wr_en(ps_wr_en), .ps_wr_addr(ps_wr_addr), .ps_wr_data(ps_wr_data),
    .ps_rd_en(ps_rd_en), .ps_rd_addr(ps_rd_addr), .ps_load_done(ps_load_done), .ps_restart(ps_restart),
    .layer_wr_en(layer_wr_en), .layer_wr_addr(layer_wr_addr), .layer_wr_data(layer_wr_data),
    .layer_rd_en(layer_rd_en), .layer_rd_addr(layer_rd_addr), .layer_done(layer_done),
    .gat_layer(a_layer), .layer_start(a_start), .rd_data(a_data), .rd_valid(a_vld),
    .all_done(a_done), .drop_cnt(a_drop));

  layer_mem_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_LAYERS(NL), .READ_LATENCY(3), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .ps_wr_en(ps_wr_en), .ps_wr_addr(ps_wr_addr), .ps_wr_data(ps_wr_data),
    .ps_rd_en(ps_rd_en), .ps_rd_addr(ps_rd_addr), .ps_load_done(ps_load_done), .ps_restart(ps_restart),
    .layer_wr_en(layer_wr_en), .layer_wr_addr(layer_wr_addr), .layer_wr_data(layer_wr_data),
    .layer_rd_en(layer_rd_en), .layer_rd_addr(layer_rd_addr), .layer_done(layer_done),
    .gat_layer(b_layer), .layer_start(b_start), .rd_data(b_data), .rd_valid(b_vld),
    .all_done(b_done), .drop_cnt(b_drop));

  int n_total = 0;
  int n_bad = 0;

  // Reference model: phase 0=load 1=run 2=drain 3=done, reads scheduled into a time wheel.
  logic [DW-1:0] mem [2][DEPTH];
  int            ph [2];
  int            lay [2];
  int            dleft [2];
  int            drop [2];
  logic [1:0]    st [2];
  bit            sv [2][8];
  logic [DW-1:0] sd [2][8];
  bit            ev [2];
  logic [DW-1:0] ed [2];
  int            cyc = 0;

  function automatic int rl_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int dmax_of(int d);
    return (d == 0) ? 65535 : 3;
  endfunction

  function automatic logic [31:0] get_out(int d, int sel);
    case (sel)
      0: return d ? 32'(b_vld) : 32'(a_vld);
      1: return d ? b_data : a_data;
      2: return d ? 32'(b_layer) : 32'(a_layer);
      3: return d ? 32'(b_start) : 32'(a_start);
      4: return d ? 32'(b_done) : 32'(a_done);
      default: return d ? 32'(b_drop) : 32'(a_drop);
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0; lay[d] = 0; dleft[d] = 0; drop[d] = 0; st[d] = '0; ev[d] = 0;
      for (int s = 0; s < 8; s++) sv[d][s] = 0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      int rl, slot;
      logic pw, pr;
      logic [1:0] lw, lr;
      rl = rl_of(d);
      pw = ps_wr_en && (ph[d] == 0 || ph[d] == 3);
      pr = ps_rd_en && (ph[d] == 3);
      lw = '0; lr = '0;
      if (ph[d] == 1) begin
        lw[lay[d]] = layer_wr_en[lay[d]];
        lr[lay[d]] = layer_rd_en[lay[d]];
      end
      if (((ps_wr_en && !pw) || (ps_rd_en && !pr) || ((layer_wr_en & ~lw) != 2'b00) ||
           ((layer_rd_en & ~lr) != 2'b00)) && drop[d] < dmax_of(d))
        drop[d]++;
      slot = (cyc + rl) % 8;
      if (pr) begin sv[d][slot] = 1; sd[d][slot] = mem[d][ps_rd_addr]; end
      if (lr != 2'b00) begin sv[d][slot] = 1; sd[d][slot] = mem[d][layer_rd_addr[lay[d]*AW +: AW]]; end
      if (pw) mem[d][ps_wr_addr] = ps_wr_data;
      if (lw != 2'b00) mem[d][layer_wr_addr[lay[d]*AW +: AW]] = layer_wr_data[lay[d]*DW +: DW];
      st[d] = '0;
      case (ph[d])
        0: if (ps_load_done) begin ph[d] = 1; lay[d] = 0; st[d] = 2'b01; end
        1: if (layer_done[lay[d]]) begin ph[d] = 2; dleft[d] = rl; end
        2: begin
          dleft[d]--;
          if (dleft[d] == 0) begin
            if (lay[d] < NL - 1) begin ph[d] = 1; lay[d]++; st[d] = 2'(1 << lay[d]); end
            else ph[d] = 3;
          end
        end
        default: if (ps_restart) begin ph[d] = 0; lay[d] = 0; end
      endcase
      slot = (cyc + 1) % 8;
      ev[d] = sv[d][slot];
      ed[d] = sd[d][slot];
      sv[d][slot] = 0;
    end
    cyc++;
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("c%0d_d%0d_rd_valid", cyc, d), get_out(d, 0), 32'(ev[d]));
      if (ev[d]) chk($sformatf("c%0d_d%0d_rd_data", cyc, d), get_out(d, 1), ed[d]);
      chk($sformatf("c%0d_d%0d_gat_layer", cyc, d), get_out(d, 2), 32'(lay[d]));
      chk($sformatf("c%0d_d%0d_layer_start", cyc, d), get_out(d, 3), 32'(st[d]));
      chk($sformatf("c%0d_d%0d_all_done", cyc, d), get_out(d, 4), 32'(ph[d] == 3));
      chk($sformatf("c%0d_d%0d_drop_cnt", cyc, d), get_out(d, 5), 32'(drop[d]));
    end
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_inputs();
    ps_wr_en = 0; ps_wr_addr = '0; ps_wr_data = '0; ps_rd_en = 0; ps_rd_addr = '0;
    ps_load_done = 0; ps_restart = 0; layer_wr_en = '0; layer_wr_addr = '0;
    layer_wr_data = '0; layer_rd_en = '0; layer_rd_addr = '0; layer_done = '0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 6; s++)
        chk($sformatf("%s_d%0d_out%0d_zero", tag, d, s), get_out(d, s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct packed {
    logic psw; logic [AW-1:0] pwa; logic [DW-1:0] pwd;
    logic psr; logic [AW-1:0] pra;
    logic ld; logic rs;
    logic [1:0] lw; logic [AW-1:0] lwa; logic [DW-1:0] lwd;
    logic [1:0] lr; logic [AW-1:0] lra; logic [1:0] ldn;
    logic evld; logic [DW-1:0] edat; logic elay; logic [1:0] est; logic edone; logic [1:0] edrop;
  } vec_t;

  function automatic vec_t ex(vec_t v, logic vld, logic [DW-1:0] dat, logic ly,
                              logic [1:0] s, logic dn, logic [1:0] dr);
    vec_t r = v;
    r.evld = vld; r.edat = dat; r.elay = ly; r.est = s; r.edone = dn; r.edrop = dr;
    return r;
  endfunction

  vec_t tv [25];

  initial begin
    clear_inputs();
    model_reset();
    #2;
    do_reset("rst0");

    // Preload every word with zero so all later reads have a known value.
    for (int i = 0; i < DEPTH; i++) begin
      ps_wr_en = 1; ps_wr_addr = AW'(i); ps_wr_data = '0;
      cycle();
    end
    clear_inputs();

    // Expected values below are for the latency-3, 2-bit-counter instance.
    for (int r = 0; r < 25; r++) tv[r] = '0;
    tv[0].psw = 1; tv[0].pwa = 5; tv[0].pwd = 32'hA5;
    tv[1].psw = 1; tv[1].pwa = 7; tv[1].pwd = 32'h77;
    tv[2].ld = 1;
    tv[3].lr = 2'b01; tv[3].lra = 5;
    tv[4].lw = 2'b10; tv[4].lwa = 7; tv[4].lwd = 32'h11;
    tv[5].lr = 2'b01; tv[5].lra = 7;
    tv[7].lr = 2'b01; tv[7].lra = 5; tv[7].ldn = 2'b01;
    tv[8].lr = 2'b01; tv[8].lra = 5;
    tv[11].lw = 2'b10; tv[11].lwa = 9; tv[11].lwd = 32'h22; tv[11].lr = 2'b10; tv[11].lra = 9;
    tv[12].lr = 2'b10; tv[12].lra = 9;
    tv[14].ldn = 2'b10;
    tv[18].psr = 1; tv[18].pra = 9;
    tv[21].rs = 1;
    tv[22].psr = 1; tv[22].pra = 9;
    tv[23].lw = 2'b11; tv[23].lwa = 1; tv[23].lwd = 32'h5;
    tv[24].lr = 2'b01; tv[24].lra = 1;
    tv[0]  = ex(tv[0],  0, 0,     0, 2'b00, 0, 0);
    tv[1]  = ex(tv[1],  0, 0,     0, 2'b00, 0, 0);
    tv[2]  = ex(tv[2],  0, 0,     0, 2'b01, 0, 0);
    tv[3]  = ex(tv[3],  0, 0,     0, 2'b00, 0, 0);
    tv[4]  = ex(tv[4],  0, 0,     0, 2'b00, 0, 1);
    tv[5]  = ex(tv[5],  1, 'hA5,  0, 2'b00, 0, 1);
    tv[6]  = ex(tv[6],  0, 0,     0, 2'b00, 0, 1);
    tv[7]  = ex(tv[7],  1, 'h77,  0, 2'b00, 0, 1);
    tv[8]  = ex(tv[8],  0, 0,     0, 2'b00, 0, 2);
    tv[9]  = ex(tv[9],  1, 'hA5,  0, 2'b00, 0, 2);
    tv[10] = ex(tv[10], 0, 0,     1, 2'b10, 0, 2);
    tv[11] = ex(tv[11], 0, 0,     1, 2'b00, 0, 2);
    tv[12] = ex(tv[12], 0, 0,     1, 2'b00, 0, 2);
    tv[13] = ex(tv[13], 1, 0,     1, 2'b00, 0, 2);
    tv[14] = ex(tv[14], 1, 'h22,  1, 2'b00, 0, 2);
    tv[15] = ex(tv[15], 0, 0,     1, 2'b00, 0, 2);
    tv[16] = ex(tv[16], 0, 0,     1, 2'b00, 0, 2);
    tv[17] = ex(tv[17], 0, 0,     1, 2'b00, 1, 2);
    tv[18] = ex(tv[18], 0, 0,     1, 2'b00, 1, 2);
    tv[19] = ex(tv[19], 0, 0,     1, 2'b00, 1, 2);
    tv[20] = ex(tv[20], 1, 'h22,  1, 2'b00, 1, 2);
    tv[21] = ex(tv[21], 0, 0,     0, 2'b00, 0, 2);
    tv[22] = ex(tv[22], 0, 0,     0, 2'b00, 0, 3);
    tv[23] = ex(tv[23], 0, 0,     0, 2'b00, 0, 3);
    tv[24] = ex(tv[24], 0, 0,     0, 2'b00, 0, 3);

    for (int r = 0; r < 25; r++) begin
      ps_wr_en = tv[r].psw; ps_wr_addr = tv[r].pwa; ps_wr_data = tv[r].pwd;
      ps_rd_en = tv[r].psr; ps_rd_addr = tv[r].pra;
      ps_load_done = tv[r].ld; ps_restart = tv[r].rs;
      layer_wr_en = tv[r].lw; layer_wr_addr = {tv[r].lwa, tv[r].lwa};
      layer_wr_data = {tv[r].lwd, tv[r].lwd};
      layer_rd_en = tv[r].lr; layer_rd_addr = {tv[r].lra, tv[r].lra};
      layer_done = tv[r].ldn;
      cycle();
      chk($sformatf("tbl%0d_rd_valid", r), 32'(b_vld), 32'(tv[r].evld));
      if (tv[r].evld) chk($sformatf("tbl%0d_rd_data", r), b_data, tv[r].edat);
      chk($sformatf("tbl%0d_gat_layer", r), 32'(b_layer), 32'(tv[r].elay));
      chk($sformatf("tbl%0d_layer_start", r), 32'(b_start), 32'(tv[r].est));
      chk($sformatf("tbl%0d_all_done", r), 32'(b_done), 32'(tv[r].edone));
      chk($sformatf("tbl%0d_drop_cnt", r), 32'(b_drop), 32'(tv[r].edrop));
    end
    clear_inputs();

    do_reset("rst1");
    for (int n = 0; n < 1500; n++) begin
      ps_wr_en = ($urandom_range(0, 9) < 3);
      ps_wr_addr = AW'($urandom_range(0, DEPTH - 1)); ps_wr_data = $urandom;
      ps_rd_en = ($urandom_range(0, 9) < 3);
      ps_rd_addr = AW'($urandom_range(0, DEPTH - 1));
      ps_load_done = ($urandom_range(0, 9) == 0);
      ps_restart = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < NL; k++) begin
        layer_wr_en[k] = ($urandom_range(0, 9) < 3);
        layer_rd_en[k] = ($urandom_range(0, 9) < 3);
        layer_done[k] = ($urandom_range(0, 9) == 0);
        layer_wr_addr[k*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        layer_rd_addr[k*AW +: AW] = ($urandom_range(0, 3) == 0) ? layer_wr_addr[k*AW +: AW]
                                                                 : AW'($urandom_range(0, DEPTH - 1));
        layer_wr_data[k*DW +: DW] = $urandom;
      end
      cycle();
    end
    clear_inputs();

    // Reset while the latency-3 read is still in its pipeline.
    do_reset("rst2");
    ps_load_done = 1;
    cycle();
    clear_inputs();
    layer_rd_en = 2'b01; layer_rd_addr = {AW'(0), AW'(5)};
    cycle();
    clear_inputs();
    do_reset("rst_midread");
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk($sformatf("post_rst%0d_b_rd_valid", n), 32'(b_vld), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
